// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: serial double-dabble binary-to-BCD converter
// with a multiplexed, active-low digit scanner for a 7-seg decoder.
module bcd_scan_driver #(
    parameter int WIDTH    = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  bin,
    input  logic              lz_blank,
    output logic              busy,
    output logic              ready,
    output logic [3:0]        digit_bcd,
    output logic [DIGITS-1:0] digit_sel
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam longint unsigned MAX_V = (64'd10 ** DIGITS) - 64'd1;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [BW-1:0]     disp_q, disp_d;
    logic              ready_q, ready_d;

    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [3:0]        nib_q, nib_d;

    logic [BW-2:0]     adj;
    logic [BW-1:0]     step_bcd;
    logic [BW-1:0]     blanked;
    logic              seen;
    logic              last;
    logic              commit;
    logic              tc;
    logic [IW-1:0]     idx_nxt;

    // Add-3 correction; the top nibble's MSB is shifted out, so skip it
    always_comb begin
        adj = bcd_q[BW-2:0];
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        if (bcd_q[BW-1 -: 4] >= 4'd5)
            adj[BW-2 -: 3] = bcd_q[BW-2 -: 3] + 3'd3;
    end

    assign step_bcd = {adj, shift_q[WIDTH-1]};
    assign last     = (cnt_q == CW'(1));

    // Blank zero digits above the highest nonzero one; digit 0 always shows
    always_comb begin
        blanked = step_bcd;
        seen    = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (step_bcd[4*i +: 4] != 4'd0)
                seen = 1'b1;
            if (lz_blank && !seen)
                blanked[4*i +: 4] = 4'hF;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = (state_q == SHIFT);
        commit = (state_q == SHIFT) && last;
    end

    // Conversion datapath next-state
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        ready_d = 1'b0;
        if (state_q == IDLE && load) begin
            shift_d = bin;
            bcd_d   = '0;
            cnt_d   = CW'(WIDTH);
            ovf_d   = (64'(bin) > MAX_V);
        end else if (busy) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            bcd_d   = step_bcd;
            cnt_d   = cnt_q - CW'(1);
        end
        if (commit) begin
            disp_d  = ovf_q ? '1 : blanked;
            ready_d = 1'b1;
        end
    end

    // Conversion datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '1;
            ready_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            ready_q <= ready_d;
        end
    end

    // Scanner next-state; reads disp_d so a commit shows by the next advance
    always_comb begin
        tc      = (pre_q == PW'(SCAN_DIV - 1));
        idx_nxt = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        pre_d   = tc ? '0 : pre_q + PW'(1);
        idx_d   = idx_q;
        sel_d   = sel_q;
        nib_d   = nib_q;
        if (tc) begin
            idx_d = idx_nxt;
            sel_d = ~(DIGITS'(1) << idx_nxt);
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_nxt == IW'(i))
                    nib_d = disp_d[4*i +: 4];
            end
        end
    end

    // Scanner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            sel_q <= ~DIGITS'(1);
            nib_q <= 4'hF;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            sel_q <= sel_d;
            nib_q <= nib_d;
        end
    end

    assign ready     = ready_q;
    assign digit_bcd = nib_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb_bcd_scan_driver: randomized and directed checks of conversion,
// blanking, overflow, handshake, reset and scanning.
module tb_bcd_scan_driver;

    localparam int W  = 14;
    localparam int D  = 4;
    localparam int SD = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] bin = '0;
    logic         lz_blank = 1'b0;
    logic         busy;
    logic         ready;
    logic [3:0]   digit_bcd;
    logic [D-1:0] digit_sel;

    int n_chk  = 0;
    int n_fail = 0;

    bcd_scan_driver #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .bin       (bin),
        .lz_blank  (lz_blank),
        .busy      (busy),
        .ready     (ready),
        .digit_bcd (digit_bcd),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by division, blanking above top nonzero
    function automatic logic [15:0] model(input int v, input bit lz);
        logic [15:0] r;
        int top;
        r = '0;
        top = 0;
        if (v > 9999) return 16'hFFFF;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
            if (r[4*i +: 4] != 4'd0) top = i;
        end
        if (lz)
            for (int i = 1; i < D; i++)
                if (i > top) r[4*i +: 4] = 4'hF;
        return r;
    endfunction

    // Expected busy cycles start+1..start+W, ready at start+W+1
    function automatic logic [63:0] exp_busy(input int start);
        logic [63:0] m;
        m = '0;
        for (int c = start + 1; c <= start + W; c++) m[c] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] exp_ready(input int start);
        logic [63:0] m;
        m = '0;
        m[start + W + 1] = 1'b1;
        return m;
    endfunction

    // Launch a conversion and record busy/ready for cycles 1..ncyc
    task automatic conv(input int v, input bit lz, input bit hold,
                        input int v2, input int ncyc,
                        output logic [63:0] bm, output logic [63:0] rm);
        bm = '0;
        rm = '0;
        @(negedge clk);
        load = 1'b1;
        bin = W'(v);
        lz_blank = lz;
        @(posedge clk);
        #1;
        if (hold) bin = W'(v2);
        else load = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            bm[c] = busy;
            rm[c] = ready;
            if (c == W) load = 1'b0;
        end
    endtask

    // Flush one frame, then record each digit's nibble by its select
    task automatic capture(output logic [15:0] got, output int bad);
        logic found;
        got = 16'hxxxx;
        bad = 0;
        repeat (D * SD) @(negedge clk);
        for (int c = 0; c < D * SD; c++) begin
            @(negedge clk);
            found = 1'b0;
            for (int i = 0; i < D; i++) begin
                if (digit_sel === ~(4'b0001 << i)) begin
                    got[4*i +: 4] = digit_bcd;
                    found = 1'b1;
                end
            end
            if (!found) bad++;
        end
    endtask

    task automatic test_reset();
        logic [3:0] es;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_busy_ready: got %b expected 00", {busy, ready});
        end
        n_chk++;
        if (digit_sel !== 4'b1110) begin
            n_fail++;
            $display("FAIL rst_sel: got %b expected 1110", digit_sel);
        end
        n_chk++;
        if (digit_bcd !== 4'hF) begin
            n_fail++;
            $display("FAIL rst_bcd: got %h expected f", digit_bcd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk);
            es = ~(4'b0001 << ((n / SD) % D));
            n_chk++;
            if (digit_sel !== es) begin
                n_fail++;
                $display("FAIL scan_sel n=%0d: got %b expected %b", n, digit_sel, es);
            end
            n_chk++;
            if (digit_bcd !== 4'hF) begin
                n_fail++;
                $display("FAIL scan_bcd n=%0d: got %h expected f", n, digit_bcd);
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, ready, digit_sel, digit_bcd} !== {2'b00, 4'b1110, 4'hF}) begin
            n_fail++;
            $display("FAIL rst_midrun: got %b_%b_%h expected 00_1110_f",
                     {busy, ready}, digit_sel, digit_bcd);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_convert(input string nm, input int v, input bit lz);
        logic [63:0] bm, rm;
        logic [15:0] got, ex;
        int bad;
        conv(v, lz, 1'b0, 0, 20, bm, rm);
        capture(got, bad);
        ex = model(v, lz);
        n_chk++;
        if (bm !== exp_busy(0)) begin
            n_fail++;
            $display("FAIL %s busy: got %h expected %h", nm, bm, exp_busy(0));
        end
        n_chk++;
        if (rm !== exp_ready(0)) begin
            n_fail++;
            $display("FAIL %s ready: got %h expected %h", nm, rm, exp_ready(0));
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s sel: got %0d bad selects expected 0", nm, bad);
        end
        for (int i = 0; i < D; i++) begin
            n_chk++;
            if (got[4*i +: 4] !== ex[4*i +: 4]) begin
                n_fail++;
                $display("FAIL %s digit%0d: got %h expected %h",
                         nm, i, got[4*i +: 4], ex[4*i +: 4]);
            end
        end
    endtask

    task automatic test_hold_load();
        logic [63:0] bm, rm;
        logic [15:0] got;
        int bad;
        conv(1234, 1'b0, 1'b1, 42, 24, bm, rm);
        capture(got, bad);
        n_chk++;
        if (rm !== exp_ready(0)) begin
            n_fail++;
            $display("FAIL hold ready: got %h expected %h", rm, exp_ready(0));
        end
        n_chk++;
        if (bm !== exp_busy(0)) begin
            n_fail++;
            $display("FAIL hold busy: got %h expected %h", bm, exp_busy(0));
        end
        n_chk++;
        if (bad !== 0 || got !== model(1234, 1'b0)) begin
            n_fail++;
            $display("FAIL hold disp: got %h (bad %0d) expected %h",
                     got, bad, model(1234, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] bm, rm;
        logic [15:0] got;
        int bad;
        bm = '0;
        rm = '0;
        @(negedge clk);
        load = 1'b1;
        bin = W'(1234);
        lz_blank = 1'b0;
        @(posedge clk);
        #1 load = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            bm[c] = busy;
            rm[c] = ready;
            if (c == W + 1) begin
                load = 1'b1;
                bin = W'(42);
            end
            if (c == W + 2) load = 1'b0;
        end
        capture(got, bad);
        n_chk++;
        if (rm !== (exp_ready(0) | exp_ready(W + 1))) begin
            n_fail++;
            $display("FAIL b2b ready: got %h expected %h",
                     rm, exp_ready(0) | exp_ready(W + 1));
        end
        n_chk++;
        if (bm !== (exp_busy(0) | exp_busy(W + 1))) begin
            n_fail++;
            $display("FAIL b2b busy: got %h expected %h",
                     bm, exp_busy(0) | exp_busy(W + 1));
        end
        n_chk++;
        if (bad !== 0 || got !== model(42, 1'b0)) begin
            n_fail++;
            $display("FAIL b2b disp: got %h (bad %0d) expected %h",
                     got, bad, model(42, 1'b0));
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] got;
        int bad;
        int pulses;
        pulses = 0;
        @(negedge clk);
        load = 1'b1;
        bin = W'(1234);
        lz_blank = 1'b0;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL midop_rst: got %b expected 00", {busy, ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (ready === 1'b1 || busy === 1'b1) pulses++;
        end
        n_chk++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL midop_quiet: got %0d active cycles expected 0", pulses);
        end
        capture(got, bad);
        n_chk++;
        if (bad !== 0 || got !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL midop_disp: got %h (bad %0d) expected ffff", got, bad);
        end
        test_convert("after_rst77", 77, 1'b0);
    endtask

    task automatic test_random();
        int v;
        bit lz;
        for (int k = 0; k < 8; k++) begin
            v = int'($urandom_range(0, 16383));
            lz = 1'($urandom_range(0, 1));
            test_convert($sformatf("rand%0d_%0d", k, v), v, lz);
        end
    endtask

    initial begin
        test_reset();
        test_convert("conv1234", 1234, 1'b0);
        test_convert("bnd9999", 9999, 1'b0);
        test_convert("bnd0", 0, 1'b0);
        test_convert("bnd0_lz", 0, 1'b1);
        test_convert("bnd1005_lz", 1005, 1'b1);
        test_convert("ovf10000", 10000, 1'b0);
        test_convert("ovf16383", 16383, 1'b1);
        test_hold_load();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_driver.md
# bcd_scan_driver

Sequential binary-to-BCD converter and multiplexed display scanner, directly upstream of the seven-segment decoder. Converts an unsigned binary value to DIGITS BCD nibbles by iterative shift-add-3 (double dabble), one bit per clock. Time-multiplexes the stored digits onto a single 4-bit nibble output plus an active-low one-hot digit select. The nibble output feeds the decoder's 4-bit input; the code 4'hF is the blank code, which the decoder renders as all segments off.

## Interface
- WIDTH, 14: binary input width, ≥ 4.
- DIGITS, 4: number of display digits.
- SCAN_DIV, 50000: clocks per digit dwell, ≥ 2.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  start conversion of `bin`; sampled only in IDLE.
- bin  in  WIDTH  unsigned value to display.
- lz_blank  in  1  1 = blank leading zeros; sampled at conversion commit.
- busy  out  1  conversion in progress.
- ready  out  1  one-cycle pulse; display register updated.
- digit_bcd  out  4  nibble for the current digit, to the seven-segment decoder.
- digit_sel  out  DIGITS  active-low one-hot digit enable; bit i = digit i, digit 0 = least significant.

## Operation
- Conversion FSM has two states, IDLE and SHIFT.
- IDLE, load=1:
  - Capture `bin` into the shift register and clear the BCD accumulator.
  - Set the bit counter to WIDTH.
  - Compute overflow = (bin > 10^DIGITS − 1).
  - Go to SHIFT.
- SHIFT, each cycle:
  - Every BCD nibble ≥ 5 gets +3.
  - Then the {BCD, binary} concatenation shifts left by one.
  - The counter decrements.
- On the last SHIFT cycle (counter reaches 1), the commit edge does the following:
  - Write the display register: all 4'hF if overflow; otherwise the BCD nibbles with lz_blank applied.
  - Pulse ready.
  - Return to IDLE.
- Leading-zero blanking: a zero digit above the highest nonzero digit becomes 4'hF. Digit 0 is never blanked.
- load while busy is ignored; the in-flight conversion is unaffected.
- The display register holds its value until the next commit.
- Scanner runs continuously and independently of the FSM:
  - Prescaler counts 0..SCAN_DIV−1.
  - At terminal count it wraps to 0 and the digit index advances modulo DIGITS (DIGITS−1 → 0).
  - On that same edge, digit_sel ← ~(1 << new index) and digit_bcd ← display[new index]. Both outputs are registered.
- A commit changes digit_bcd no later than the next digit advance. The current dwell shows the old nibble.

## Timing
- Reset values (asynchronous, immediate):
  - busy=0, ready=0.
  - State IDLE.
  - Display register all 4'hF.
  - Prescaler 0, index 0.
  - digit_sel = ~1 (4'b1110 for DIGITS=4).
  - digit_bcd = 4'hF.
- Latency: load sampled at edge 0.
  - busy=1 for cycles 1..WIDTH.
  - ready=1 in cycle WIDTH+1, with busy=0 and the display register already updated.
- busy = (state == SHIFT).
- ready is a 1-cycle pulse, never asserted with busy.
- A load asserted in the ready cycle is accepted, since the FSM is in IDLE. Back-to-back conversions therefore take WIDTH+1 cycles each.
- Reset mid-conversion aborts it: no ready pulse, display blank.
- BCD accumulator width is 4·DIGITS. Overflowed upper bits are discarded; the overflow flag overrides.
- Scan period: each digit is held for exactly SCAN_DIV clocks; the full frame lasts DIGITS·SCAN_DIV clocks.

## Test plan
Bench uses WIDTH=14, DIGITS=4, SCAN_DIV=4.
- Reset: assert rst_n=0 mid-run → immediately busy=0, ready=0, digit_sel=1110, digit_bcd=F. After release, digit_sel steps 1101, 1011, 0111, 1110 every 4 clocks; digit_bcd stays F.
- Convert and scan: load bin=1234, lz_blank=0 at edge 0 → busy high cycles 1–14, ready pulse at cycle 15. Over one frame, digit_bcd reads 4,3,2,1 with digit_sel 1110,1101,1011,0111.
- Boundary values:
  - bin=9999 → 9,9,9,9.
  - bin=0, lz_blank=0 → 0,0,0,0.
  - bin=0, lz_blank=1 → 0,F,F,F (digits 0..3).
  - bin=1005, lz_blank=1 → 5,0,0,1 (no interior blanking).
- Overflow: bin=10000 and bin=16383 → all digits F, ready still pulses at cycle 15.
- Handshake:
  - load=1 held through busy with bin changing to 42 → exactly one conversion of the initially captured 1234.
  - A load in the ready cycle with bin=42 → second ready 15 cycles later; display reads 2,4,0,0.
- Reset mid-op: load 1234, drop rst_n at cycle 7 → no ready pulse, display all F. A subsequent load of 77 converts normally to 7,7,0,0.
